// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter and its round-robin picker.
// Contents: FSM state encoding, well-known source IDs, index-width helper.
package uart_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_BYTE = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_ACK  = 3'd3,
    ST_WAIT_DONE = 3'd4
  } arb_state_e;

  localparam int unsigned SRC_TRAVERSE = 0;
  localparam int unsigned SRC_CALC     = 1;
  localparam int unsigned SRC_MSG      = 2;

  // Bits needed to hold an index in 0..n-1, never less than one.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i,
// wrapping modulo N.
// Ports: req_i  request vector
//        ptr_i  round-robin start index
//        gnt_c_o one-hot pick (zero when no request)
//        idx_c_o binary index of the pick
//        found_c_o any request set
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int unsigned N  = 3,
  parameter int unsigned IW = idx_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_c_o,
  output logic [IW-1:0] idx_c_o,
  output logic          found_c_o
);

  logic [IW-1:0] cand;

  // Scan N candidates starting at the pointer; the first hit wins.
  always_comb begin
    gnt_c_o   = '0;
    idx_c_o   = '0;
    found_c_o = 1'b0;
    cand      = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IW'((32'(ptr_i) + k) % N);
      if (!found_c_o && req_i[cand]) begin
        found_c_o     = 1'b1;
        gnt_c_o[cand] = 1'b1;
        idx_c_o       = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx serializer between NUM_REQ byte-stream producers.
// Round-robin grant with packet lock: the owner keeps the UART until its
// last byte has been transmitted or it drops req at a byte boundary.
// Ports: clk, rst_n (async active-low)
//        req/valid/last/data  per-source packet request, byte valid, last flag, byte
//        ready   one-cycle accept pulse to the owner
//        grant   one-hot owner, zero when free; arb_busy = |grant
//        uart_tx_start/uart_tx_data/uart_tx_busy  handshake with uart_tx
//        wdog_flag  one-cycle pulse on forced release
// Build option: define ARB_WATCHDOG_EN to build the idle-byte watchdog
// (WDOG_CYCLES); otherwise wdog_flag is tied low and the owner may wait forever.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 3,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned WDOG_CYCLES = 1000000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            valid,
  input  logic [NUM_REQ-1:0]            last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data,
  output logic [NUM_REQ-1:0]            ready,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          uart_tx_start,
  output logic [DATA_WIDTH-1:0]         uart_tx_data,
  input  logic                          uart_tx_busy,
  output logic                          arb_busy,
  output logic                          wdog_flag
);

  localparam int unsigned   IW       = idx_width(NUM_REQ);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);

  arb_state_e              state_q, state_d;
  logic [NUM_REQ-1:0]      grant_q, grant_d;
  logic [NUM_REQ-1:0]      ready_q, ready_d;
  logic [IW-1:0]           owner_q, owner_d;
  logic [IW-1:0]           rr_ptr_q, rr_ptr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    last_q, last_d;
  logic                    start_q, start_d;
  logic                    arb_busy_q;
  logic                    release_c;
  logic                    timeout_c;

  logic [NUM_REQ-1:0]      pick_gnt;
  logic [IW-1:0]           pick_idx;
  logic                    pick_found;

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req_i     (req),
    .ptr_i     (rr_ptr_q),
    .gnt_c_o   (pick_gnt),
    .idx_c_o   (pick_idx),
    .found_c_o (pick_found)
  );

`ifdef ARB_WATCHDOG_EN
  localparam int unsigned CW = idx_width(WDOG_CYCLES);

  logic [CW-1:0] wdog_cnt_q, wdog_cnt_d;
  logic          wdog_q, wdog_d;

  assign timeout_c = (wdog_cnt_q == CW'(WDOG_CYCLES - 1));
  // Forced release only when the owner still requests but never offers a byte.
  assign wdog_d    = (state_q == ST_WAIT_BYTE) && req[owner_q] && !valid[owner_q] && timeout_c;
  // Counts consecutive WAIT_BYTE cycles; any exit clears it.
  assign wdog_cnt_d = (state_q == ST_WAIT_BYTE && state_d == ST_WAIT_BYTE) ?
                      wdog_cnt_q + CW'(1) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt_q <= '0;
      wdog_q     <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      wdog_q     <= wdog_d;
    end
  end

  assign wdog_flag = wdog_q;
`else
  assign timeout_c = 1'b0;
  assign wdog_flag = 1'b0;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    data_d    = data_q;
    last_d    = last_q;
    ready_d   = '0;
    start_d   = 1'b0;
    release_c = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_found && !uart_tx_busy) begin
          grant_d = pick_gnt;
          owner_d = pick_idx;
          state_d = ST_WAIT_BYTE;
        end
      end
      ST_WAIT_BYTE: begin
        if (!req[owner_q]) begin
          release_c = 1'b1;
        end else if (valid[owner_q]) begin
          ready_d[owner_q] = 1'b1;
          data_d           = data[32'(owner_q) * DATA_WIDTH +: DATA_WIDTH];
          last_d           = last[owner_q];
          state_d          = ST_START;
        end else if (timeout_c) begin
          release_c = 1'b1;
        end
      end
      ST_START: begin
        start_d = 1'b1;
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (uart_tx_busy) state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (!uart_tx_busy) begin
          if (last_q) release_c = 1'b1;
          else        state_d   = ST_WAIT_BYTE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Release hands the pointer to the source after the owner.
    if (release_c) begin
      grant_d  = '0;
      rr_ptr_d = (owner_q == LAST_IDX) ? '0 : owner_q + IW'(1);
      state_d  = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      ready_q    <= '0;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      data_q     <= '0;
      last_q     <= 1'b0;
      start_q    <= 1'b0;
      arb_busy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ready_q    <= ready_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      data_q     <= data_d;
      last_q     <= last_d;
      start_q    <= start_d;
      arb_busy_q <= |grant_d;
    end
  end

  assign grant         = grant_q;
  assign ready         = ready_q;
  assign uart_tx_start = start_q;
  assign uart_tx_data  = data_q;
  assign arb_busy      = arb_busy_q;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single uart_tx serializer between several byte-stream producers: matrix traversal printout, calculation result printer and status/error message generator.
- Round-robin grant with packet lock: a granted source owns the UART until it flags its last byte or drops its request.
- Sits between the producers and uart_tx; it alone drives tx_start/tx_data and watches tx_busy.

Parameters:
NUM_REQ, 3, number of requesting sources (2..8)
DATA_WIDTH, 8, byte width
WDOG_CYCLES, 1000000, idle-byte timeout in clk cycles (used only with ARB_WATCHDOG_EN)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req  in  NUM_REQ  per-source packet request; level, held for the whole packet
valid  in  NUM_REQ  per-source byte valid
last  in  NUM_REQ  per-source "this byte is last of packet", sampled with valid
data  in  NUM_REQ*DATA_WIDTH  per-source byte; source i at [i*DATA_WIDTH +: DATA_WIDTH]
ready  out  NUM_REQ  one-cycle pulse: byte of that source accepted
grant  out  NUM_REQ  one-hot current owner, all-zero when free
uart_tx_start  out  1  one-cycle start pulse to uart_tx
uart_tx_data  out  DATA_WIDTH  registered byte to uart_tx
uart_tx_busy  in  1  uart_tx busy
arb_busy  out  1  high whenever grant is non-zero
wdog_flag  out  1  one-cycle pulse on forced release (constant 0 without macro)

Behaviour:
- One clock domain (clk); asynchronous active-low reset rst_n.
- Reset values: grant, ready, uart_tx_start, arb_busy and wdog_flag are 0; uart_tx_data is 0; rr_ptr is 0; state is IDLE. Asserting rst_n low mid-byte aborts immediately. No byte is replayed after reset.
- FSM states: IDLE, WAIT_BYTE, START, WAIT_ACK, WAIT_DONE.
- IDLE:
  - If req is non-zero and uart_tx_busy is 0, pick the first set req bit at or above rr_ptr, wrapping modulo NUM_REQ.
  - Register the one-hot grant and go to WAIT_BYTE.
  - Grant appears one cycle after req is seen.
- WAIT_BYTE:
  - If the owner's req is low, release.
  - Otherwise, when the owner's valid is high: pulse ready[owner] for 1 cycle, latch data into uart_tx_data, latch last into last_q, go to START.
  - valid on non-owners is ignored; their ready stays 0.
- START: uart_tx_start=1 for exactly one cycle, go to WAIT_ACK. Latency from accepted valid to tx_start is 1 cycle.
- WAIT_ACK: wait for uart_tx_busy=1, then go to WAIT_DONE.
- WAIT_DONE:
  - Wait for uart_tx_busy=0.
  - If last_q=1, release; else go to WAIT_BYTE.
- Release: grant becomes 0, rr_ptr = (owner+1) mod NUM_REQ, state returns to IDLE. The freed source cannot regain the grant in the same cycle.
- Fairness: with all sources requesting continuously, packet order is 0,1,2,0,...
- A req rising while another source owns the UART waits; it is never lost, because req is a level.
- A source dropping req mid-packet is released only at a byte boundary (WAIT_BYTE), never during a byte in flight.
- valid together with req in the same cycle in IDLE: grant first, accept the byte in the following cycle.
- Exactly one tx_start per accepted byte; tx_start is never issued while uart_tx_busy=1.

Optional Feature:
ARB_WATCHDOG_EN:
- Defined:
  - A counter runs only in WAIT_BYTE and clears on leaving it.
  - When the counter reaches WDOG_CYCLES-1, force release: rr_ptr advances and wdog_flag pulses 1 cycle.
  - A hung producer cannot lock the UART.
- Undefined: no counter is built, wdog_flag is tied 0, and the owner may wait indefinitely.

Decomposition:
- Shared package uart_arb_pkg holds:
  - state encodings;
  - source ID constants SRC_TRAVERSE=0, SRC_CALC=1, SRC_MSG=2;
  - a function for the index width, $clog2-style, min 1.
- One natural sub-module: rr_pick, a combinational round-robin picker (req, rr_ptr -> one-hot grant, binary idx). It is reusable by the storage-port scheduler.

Test Plan:
- Single source 1 sends 3 bytes 0x41,0x42,0x43 (last on 0x43) -> grant=3'b010, three tx_start pulses each 1 cycle after ready, data in order, grant=0 after the third busy falls.
- req=3'b111 held, each source sends 1-byte packets -> grant order 001,010,100,001; rr_ptr wraps to 0.
- Source 0 owns a 4-byte packet, source 2 raises req after byte 1 -> no interleaving; source 2 is granted only after source 0's last byte completes.
- Source 1 drops req after byte 2 of 5 while byte 2 is in flight -> byte 2 completes, release in WAIT_BYTE, no further tx_start.
- rst_n pulsed low during WAIT_DONE -> all outputs 0 immediately, next request is served from rr_ptr=0.
- With ARB_WATCHDOG_EN and WDOG_CYCLES=16: owner holds req with no valid -> forced release after 16 cycles in WAIT_BYTE, wdog_flag 1-cycle pulse, next requester granted.
